// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, default
// instruction-memory geometry and the length-header size.
// Build option: PROG_LOADER_CHECKSUM_EN adds the trailing checksum state.
package prog_loader_pkg;

    localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_IMEM_BYTES = 32'h0020_0000;

    // Length header is a 4-byte little-endian word.
    localparam int LEN_HDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK   = 3'd4,
`endif
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Byte-to-word little-endian shifter. Each accepted byte enters at the top
// and moves down, so after four bytes the first one sits in bits [7:0].
// The byte count wraps every four bytes; full flags the fourth byte.
module prog_loader_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [31:0] word_nxt,
    output logic [1:0]  cnt,
    output logic        full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;

    // Shift in a byte and advance the count when enabled.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (shift_en) begin
            word_d = {byte_in, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // Word and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= 32'h0;
            cnt_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word     = word_q;
    assign word_nxt = word_d;
    assign cnt      = cnt_q;
    assign full     = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream and writes it as
// little-endian 32-bit words into instruction memory starting at IMEM_BASE,
// holding the CPU in reset until the whole image has landed.
// Build option: PROG_LOADER_CHECKSUM_EN appends a one-byte additive checksum
// after the payload; a mismatch rejects the image.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
    parameter logic [31:0] IMEM_BYTES = DEF_IMEM_BYTES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_wready,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        error
);

    localparam logic [1:0] HDR_LAST_IDX = 2'(LEN_HDR_BYTES - 1);

    state_e      state_q, state_d;
    logic [31:0] len_q, len_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    logic        accept;
    logic        shift_en;
    logic [31:0] pack_word;
    logic [31:0] pack_word_nxt;
    logic [1:0]  pack_cnt;
    logic        pack_full;
    logic [31:0] cnt_inc;
    logic        len_bad;

    assign accept   = rx_valid && rx_ready;
    // Header and payload bytes both go through the packer; the header fills
    // exactly one word, so payload words stay aligned to the byte count.
    assign shift_en = accept && ((state_q == ST_IDLE) || (state_q == ST_LEN) ||
                                 (state_q == ST_DATA));
    assign cnt_inc  = cnt_q + 32'd4;
    assign len_bad  = (pack_word_nxt == 32'h0) || (pack_word_nxt[1:0] != 2'b00) ||
                      (pack_word_nxt > IMEM_BYTES);

    prog_loader_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .byte_in  (rx_data),
        .word     (pack_word),
        .word_nxt (pack_word_nxt),
        .cnt      (pack_cnt),
        .full     (pack_full)
    );

    // Next-state and handshake decode.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rx_ready = 1'b1;
                if (accept) state_d = ST_LEN;
            end
            ST_LEN: begin
                rx_ready = 1'b1;
                if (accept && (pack_cnt == HDR_LAST_IDX)) begin
                    len_d   = pack_word_nxt;
                    state_d = len_bad ? ST_ERR : ST_DATA;
                end
            end
            ST_DATA: begin
                rx_ready = 1'b1;
                if (accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (pack_full) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                if (mem_wready) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        // Address stays on the last word written.
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        state_d = ST_DATA;
                    end
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                rx_ready = 1'b1;
                if (accept) state_d = (rx_data == sum_q) ? ST_DONE : ST_ERR;
            end
`endif
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and address registers; reset discards any partial image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= 32'h0;
            cnt_q   <= 32'h0;
            addr_q  <= IMEM_BASE;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= 8'h0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = pack_word;
    assign done      = (state_q == ST_DONE);
    assign cpu_rst_n = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: nominal image, header rejects, write
// back-pressure, reset during load and (when built with
// PROG_LOADER_CHECKSUM_EN) checksum accept/reject.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wready = 1'b1;
    logic        cpu_rst_n;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [31:0] wr_addr [32];
    logic [31:0] wr_data [32];
    int          wr_n = 0;
    int          we_cycles = 0;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .error      (error)
    );

    // Memory-side monitor: logs every completed write, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            we_cycles <= we_cycles + 1;
            if (mem_wready && wr_n < 32) begin
                wr_addr[wr_n] <= mem_addr;
                wr_data[wr_n] <= mem_wdata;
                wr_n          <= wr_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  acc;
        n   = 0;
        acc = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && n < 100) begin
            @(negedge clk);
            if (rx_ready === 1'b1) acc = 1'b1;
            n++;
        end
        if (!acc) check_eq("send_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic do_reset();
        rx_valid   = 1'b0;
        mem_wready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done && !error && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        int base;
        int base_we;
        int ok;

        // Reset values while rst_n is held low
        #3;
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd1);
        check_eq("rst_mem_we", 32'(mem_we), 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'h0);
        check_eq("rst_mem_wdata", mem_wdata, 32'h0);
        check_eq("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal two-word image
        base = wr_n;
        send_word(32'd8);
        send_word(32'h0000_0013);
        check_eq("lat_mem_we", 32'(mem_we), 32'd1);
        check_eq("lat_mem_addr", mem_addr, 32'h0);
        check_eq("lat_mem_wdata", mem_wdata, 32'h0000_0013);
        check_eq("lat_rx_ready", 32'(rx_ready), 32'd0);
        send_word(32'h0010_0093);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'hB6);
`endif
        wait_end();
        check_eq("img_wr_count", 32'(wr_n - base), 32'd2);
        check_eq("img_wr0_addr", wr_addr[base], 32'h0);
        check_eq("img_wr0_data", wr_data[base], 32'h0000_0013);
        check_eq("img_wr1_addr", wr_addr[base + 1], 32'h4);
        check_eq("img_wr1_data", wr_data[base + 1], 32'h0010_0093);
        check_eq("img_done", 32'(done), 32'd1);
        check_eq("img_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        check_eq("img_error", 32'(error), 32'd0);
        check_eq("img_last_addr", mem_addr, 32'h4);
        check_eq("img_rx_ready", 32'(rx_ready), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("img_done_hold", 32'(done), 32'd1);

        // Unaligned length rejected
        do_reset();
        base_we = we_cycles;
        send_word(32'd6);
        @(negedge clk);
        check_eq("len6_error", 32'(error), 32'd1);
        check_eq("len6_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check_eq("len6_rx_ready", 32'(rx_ready), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("len6_no_we", 32'(we_cycles - base_we), 32'd0);
        check_eq("len6_err_hold", 32'(error), 32'd1);
        check_eq("len6_done", 32'(done), 32'd0);

        // Zero length rejected
        do_reset();
        send_word(32'd0);
        @(negedge clk);
        check_eq("len0_error", 32'(error), 32'd1);

        // Length one word over memory size rejected right after header
        do_reset();
        send_word(32'h0020_0004);
        check_eq("lenbig_error", 32'(error), 32'd1);

        // Length exactly memory size accepted
        do_reset();
        send_word(32'h0020_0000);
        check_eq("lenmax_error", 32'(error), 32'd0);
        check_eq("lenmax_rx_ready", 32'(rx_ready), 32'd1);

        // Write back-pressure: five stalled cycles
        do_reset();
        base = wr_n;
        mem_wready = 1'b0;
        send_word(32'd4);
        send_word(32'hDDCC_BBAA);
        ok = 0;
        repeat (5) begin
            @(negedge clk);
            if (mem_we === 1'b1 && mem_addr === 32'h0 && mem_wdata === 32'hDDCC_BBAA &&
                rx_ready === 1'b0)
                ok++;
        end
        check_eq("stall_stable", 32'(ok), 32'd5);
        check_eq("stall_no_write", 32'(wr_n - base), 32'd0);
        @(posedge clk);
        #1;
        mem_wready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h0E);
`endif
        wait_end();
        check_eq("stall_wr_count", 32'(wr_n - base), 32'd1);
        check_eq("stall_wr_data", wr_data[base], 32'hDDCC_BBAA);
        check_eq("stall_done", 32'(done), 32'd1);

        // Reset after six payload bytes, then reload a fresh image
        do_reset();
        send_word(32'd8);
        send_word(32'h4433_2211);
        send_byte(8'h55);
        send_byte(8'h66);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        check_eq("midrst_mem_we", 32'(mem_we), 32'd0);
        check_eq("midrst_rx_ready", 32'(rx_ready), 32'd1);
        check_eq("midrst_mem_addr", mem_addr, 32'h0);
        check_eq("midrst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = wr_n;
        send_word(32'd4);
        send_word(32'hDEAD_BEEF);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h38);
`endif
        wait_end();
        check_eq("reload_wr_count", 32'(wr_n - base), 32'd1);
        check_eq("reload_wr_addr", wr_addr[base], 32'h0);
        check_eq("reload_wr_data", wr_data[base], 32'hDEAD_BEEF);
        check_eq("reload_done", 32'(done), 32'd1);

        // Reset while a write is pending drops mem_we at once
        do_reset();
        mem_wready = 1'b0;
        send_word(32'd4);
        send_word(32'h1234_5678);
        check_eq("wrrst_we_before", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("wrrst_we_after", 32'(mem_we), 32'd0);
        check_eq("wrrst_addr", mem_addr, 32'h0);
        mem_wready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum accepted
        do_reset();
        base = wr_n;
        send_word(32'd4);
        send_word(32'h0403_0201);
        send_byte(8'h0A);
        wait_end();
        check_eq("csum_ok_done", 32'(done), 32'd1);
        check_eq("csum_ok_error", 32'(error), 32'd0);

        // Checksum rejected after the write was issued
        do_reset();
        base = wr_n;
        send_word(32'd4);
        send_word(32'h0403_0201);
        send_byte(8'h0B);
        wait_end();
        check_eq("csum_bad_error", 32'(error), 32'd1);
        check_eq("csum_bad_done", 32'(done), 32'd0);
        check_eq("csum_bad_wr_count", 32'(wr_n - base), 32'd1);
        check_eq("csum_bad_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
